// File: rtl/spi_3wire_master.sv
// rtl/spi_3wire_master.sv - 3-wire SPI master, shared SDAT line; define SPI3W_CS_GAP_EN for a chip-enable gap after each frame
module spi_3wire_master #(
    parameter int DATA_W  = 16,
    parameter int CMD_W   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic                    GO,
    input  logic [DATA_W-1:0]       regdata,
    output logic                    SPC,
    inout  wire                     SDAT,
    output logic                    SCEN,
    output logic                    ORDY,
    output logic [DATA_W-CMD_W-1:0] rdata,
    output logic                    rvalid
);

    localparam int RX_W  = DATA_W - CMD_W;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    // Transmitted-bit count at which the first data bit starts.
    localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(CMD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic              r_half;      // 0 = SPC low half of a bit, 1 = high half
    logic [BIT_W-1:0]  r_bit;       // bits fully transmitted so far
    logic [DATA_W-1:0] r_shift;
    logic              r_rw;
    logic [RX_W-1:0]   r_rx;
    logic [RX_W-1:0]   r_rdata;
    logic              r_rvalid;

    logic w_div_end;
    logic w_bit_end;
    logic w_spc_rise;
    logic w_in_data;
    logic w_spc;
    logic w_scen;
    logic w_ordy;
    logic w_sdat_oe;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_bit_end  = (r_state == S_SHIFT) && r_half && w_div_end;
    assign w_spc_rise = (r_state == S_SHIFT) && !r_half && w_div_end;
    assign w_in_data  = r_rw && (r_bit >= BIT_DATA0);

    // State register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every timed state lasts whole divider periods.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (GO) w_state_nxt = S_LEAD;
            S_LEAD:  if (w_div_end) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && (r_bit == BIT_LAST)) w_state_nxt = S_TRAIL;
`ifdef SPI3W_CS_GAP_EN
            S_TRAIL: if (w_div_end) w_state_nxt = S_GAP;
            S_GAP:   if (w_div_end) w_state_nxt = S_IDLE;
`else
            S_TRAIL: if (w_div_end) w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode; SCEN stays high in IDLE and GAP.
    always_comb begin
        w_ordy    = (r_state == S_IDLE);
        w_scen    = 1'b1;
        w_spc     = 1'b1;
        w_sdat_oe = 1'b0;
        case (r_state)
            S_LEAD: begin
                w_scen    = 1'b0;
                w_sdat_oe = 1'b1;
            end
            S_SHIFT: begin
                w_scen    = 1'b0;
                w_spc     = r_half;
                w_sdat_oe = !w_in_data;
            end
            S_TRAIL: w_scen = 1'b0;
            default: ;
        endcase
    end

    // Divider, bit counter, shift registers and read-data capture.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_half   <= 1'b0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_rw     <= 1'b0;
            r_rx     <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;

            if ((r_state == S_IDLE) || w_div_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (r_state != S_SHIFT) begin
                r_half <= 1'b0;
            end else if (w_div_end) begin
                r_half <= ~r_half;
            end

            if (r_state == S_IDLE) begin
                r_bit <= '0;
            end else if (w_bit_end) begin
                r_bit <= r_bit + 1'b1;
            end

            if ((r_state == S_IDLE) && GO) begin
                r_shift <= regdata;
                r_rw    <= regdata[DATA_W-1];
            end else if (w_bit_end) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end

            // SDAT is taken directly at the edge where SPC rises; the slave
            // has had a full low half-period to settle it.
            if (w_spc_rise && w_in_data) begin
                r_rx <= RX_W'({r_rx, SDAT});
            end

            if ((r_state == S_TRAIL) && w_div_end && r_rw) begin
                r_rdata  <= r_rx;
                r_rvalid <= 1'b1;
            end
        end
    end

    assign SPC    = w_spc;
    assign SCEN   = w_scen;
    assign ORDY   = w_ordy;
    assign SDAT   = w_sdat_oe ? r_shift[DATA_W-1] : 1'bz;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_spi_3wire_master.sv
// tb/tb_spi_3wire_master.sv - scoreboard bench for spi_3wire_master with serial slave models
module tb_spi_3wire_master;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int CD = 2;
    localparam int RX = DW - CW;
`ifdef SPI3W_CS_GAP_EN
    localparam int GAP_EXTRA = 1;
`else
    localparam int GAP_EXTRA = 0;
`endif
    localparam int FRAME_CYC  = CD * (2 * DW + 2 + GAP_EXTRA);
    localparam int FRAME6_CYC = 1 * (2 * 24 + 2 + GAP_EXTRA);

    logic          CLK = 1'b0;
    logic          reset_n;
    logic          GO;
    logic [DW-1:0] regdata;
    logic          SPC;
    wire           sdat;
    logic          SCEN;
    logic          ORDY;
    logic [RX-1:0] rdata;
    logic          rvalid;

    logic          go6;
    logic [23:0]   regdata6;
    logic          spc6;
    wire           sdat6;
    logic          scen6;
    logic          ordy6;
    logic [15:0]   rdata6;
    logic          rvalid6;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    spi_3wire_master #(.DATA_W(DW), .CMD_W(CW), .CLK_DIV(CD)) u_dut (
        .CLK(CLK), .reset_n(reset_n), .GO(GO), .regdata(regdata),
        .SPC(SPC), .SDAT(sdat), .SCEN(SCEN), .ORDY(ORDY),
        .rdata(rdata), .rvalid(rvalid)
    );

    spi_3wire_master #(.DATA_W(24), .CMD_W(8), .CLK_DIV(1)) u_dut6 (
        .CLK(CLK), .reset_n(reset_n), .GO(go6), .regdata(regdata6),
        .SPC(spc6), .SDAT(sdat6), .SCEN(scen6), .ORDY(ordy6),
        .rdata(rdata6), .rvalid(rvalid6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: frame word and slave read data per issued frame.
    logic [DW-1:0] exp_d_q[$];
    logic [RX-1:0] exp_s_q[$];
    logic [RX-1:0] slave_q[$];

    // Slave model: learns R/W from the first command bit, answers reads.
    logic          slv_oe = 1'b0;
    logic          slv_do = 1'b0;
    logic          slv_act = 1'b0;
    logic          slv_rw = 1'b0;
    logic          slv_spc_q = 1'b1;
    logic [RX-1:0] slv_data = '0;
    int            slv_cmd = 0;
    int            slv_fall = 0;
    assign sdat = slv_oe ? slv_do : 1'bz;

    always @(SPC or SCEN) begin
        if (SCEN) begin
            slv_oe  = 1'b0;
            slv_act = 1'b0;
        end else begin
            if (!slv_act) begin
                slv_act  = 1'b1;
                slv_cmd  = 0;
                slv_fall = 0;
                slv_rw   = 1'b0;
                slv_data = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
            end
            if (SPC && !slv_spc_q && slv_cmd < CW) begin
                if (slv_cmd == 0) slv_rw = sdat;
                slv_cmd++;
            end
            if (!SPC && slv_spc_q) begin
                slv_fall++;
                if (slv_rw && slv_fall > CW && slv_fall <= DW) begin
                    slv_oe = 1'b1;
                    slv_do = slv_data[RX-1-(slv_fall-CW-1)];
                end
            end
        end
        slv_spc_q = SPC;
    end

    // Fixed-data slave for the wide, undivided instance (always answers 16'hBEEF).
    logic        s6_oe = 1'b0;
    logic        s6_do = 1'b0;
    logic        s6_spc_q = 1'b1;
    logic [15:0] s6_data = 16'hBEEF;
    int          s6_fall = 0;
    assign sdat6 = s6_oe ? s6_do : 1'bz;

    always @(spc6 or scen6) begin
        if (scen6) begin
            s6_oe   = 1'b0;
            s6_fall = 0;
        end else if (!spc6 && s6_spc_q) begin
            s6_fall++;
            if (s6_fall > 8 && s6_fall <= 24) begin
                s6_oe = 1'b1;
                s6_do = s6_data[24-s6_fall];
            end
        end
        s6_spc_q = spc6;
    end

    // Monitor: gathers each frame on the falling clock edge and scores it at ORDY rise.
    int            in_frame = 0;
    int            low_len = 0;
    int            pulses = 0;
    int            rv_cnt = 0;
    int            idle_len = 0;
    int            last_idle = 0;
    logic          prev_spc = 1'b1;
    logic [DW-1:0] cap = '0;
    logic [RX-1:0] rv_val = '0;
    logic [RX-1:0] last_rdata = '0;

    task automatic end_frame();
        logic [DW-1:0] d;
        logic [RX-1:0] s;
        logic          rw;
        if (exp_d_q.size() == 0) begin
            chk("unexpected_frame", 32'd0, 32'd1);
        end else begin
            d  = exp_d_q.pop_front();
            s  = exp_s_q.pop_front();
            rw = d[DW-1];
            chk("ordy_low_cycles", low_len, FRAME_CYC);
            chk("spc_pulses", pulses, DW);
            chk("sdat_bits", 32'(cap), rw ? 32'({d[DW-1:RX], s}) : 32'(d));
            chk("rvalid_count", rv_cnt, 32'(rw));
            if (rw) begin
                chk("rdata", 32'(rv_val), 32'(s));
                last_rdata = s;
            end else begin
                chk("rdata_hold", 32'(rdata), 32'(last_rdata));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!reset_n) begin
            in_frame   = 0;
            idle_len   = 0;
            last_rdata = '0;
            exp_d_q.delete();
            exp_s_q.delete();
        end else if (in_frame != 0) begin
            if (!prev_spc && SPC) begin
                pulses++;
                cap = {cap[DW-2:0], sdat};
            end
            if (rvalid) begin
                rv_cnt++;
                rv_val = rdata;
            end
            if (!ORDY) begin
                low_len++;
            end else begin
                in_frame = 0;
                end_frame();
                idle_len = 1;
            end
        end else begin
            if (rvalid) chk("rvalid_outside_frame", 32'(rvalid), 32'd0);
            if (!ORDY) begin
                in_frame  = 1;
                low_len   = 1;
                pulses    = 0;
                rv_cnt    = 0;
                cap       = '0;
                last_idle = idle_len;
            end else begin
                idle_len++;
            end
        end
        prev_spc = SPC;
    end

    task automatic send_frame(input logic [DW-1:0] d, input logic [RX-1:0] s, input bit hold);
        int n;
        exp_d_q.push_back(d);
        exp_s_q.push_back(s);
        slave_q.push_back(s);
        n = 0;
        @(negedge CLK);
        while (!ORDY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 1000) chk("ready_timeout", 32'd0, 32'd1);
        regdata = d;
        GO      = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) GO = 1'b0;
        regdata = DW'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(ORDY && exp_d_q.size() == 0) && n < 2000);
        if (n >= 2000) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   n;
        int   cnt;
        int   low;
        int   pul;
        int   rvc;
        bit   done;
        logic p;
        logic [15:0] rvv;

        reset_n  = 1'b0;
        GO       = 1'b0;
        regdata  = '0;
        go6      = 1'b0;
        regdata6 = '0;
        repeat (3) @(negedge CLK);
        chk("rst_spc", 32'(SPC), 32'd1);
        chk("rst_scen", 32'(SCEN), 32'd1);
        chk("rst_ordy", 32'(ORDY), 32'd1);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed write and read frames.
        send_frame(16'h2A55, 8'h00, 1'b0);
        wait_done();
        send_frame(16'hA900, 8'h5C, 1'b0);
        wait_done();

        // GO pulses around cycles 10 and 40 of a busy frame must be ignored.
        send_frame(16'h1234, 8'h00, 1'b0);
        repeat (9) @(posedge CLK);
        #1 GO = 1'b1; regdata = 16'hFFFF;
        @(posedge CLK);
        #1 GO = 1'b0;
        repeat (29) @(posedge CLK);
        #1 GO = 1'b1; regdata = 16'h8001;
        @(posedge CLK);
        #1 GO = 1'b0;
        wait_done();
        repeat (5) @(negedge CLK);
        chk("busy_no_restart", 32'(ORDY), 32'd1);

        // Randomized frames, some with GO held over ORDY rise.
        for (int i = 0; i < 20; i++) begin
            send_frame(DW'($urandom), RX'($urandom), ($urandom_range(0, 3) == 0));
        end
        GO = 1'b0;
        wait_done();

        // Back-to-back: GO held, next frame begins one cycle after ORDY rises.
        send_frame(16'h8F00, RX'($urandom), 1'b1);
        send_frame(16'h3C3C, 8'h00, 1'b1);
        @(negedge CLK);
        #1;
        chk("b2b_ordy_high_cycles", last_idle, 32'd1);
        GO = 1'b0;
        wait_done();

        // Make rdata non-zero, then reset in the middle of bit 5 of a read.
        send_frame(16'hC000, 8'hA7, 1'b0);
        wait_done();
        send_frame(16'hA900, 8'h33, 1'b0);
        n = 0;
        cnt = 0;
        p = SPC;
        while (cnt < 5 && n < 500) begin
            @(negedge CLK);
            n++;
            if (!p && SPC) cnt++;
            p = SPC;
        end
        chk("t1_reached_bit5", 32'(cnt), 32'd5);
        @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_spc", 32'(SPC), 32'd1);
        chk("t1_scen", 32'(SCEN), 32'd1);
        chk("t1_ordy", 32'(ORDY), 32'd1);
        chk("t1_rdata", 32'(rdata), 32'd0);
        chk("t1_rvalid", 32'(rvalid), 32'd0);
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Recovery after abort.
        send_frame(16'hB100, 8'h96, 1'b0);
        wait_done();

        // Wide frame, undivided clock, read returns 16'hBEEF.
        regdata6 = 24'h8C1234;
        @(negedge CLK);
        go6 = 1'b1;
        @(posedge CLK);
        #1 go6 = 1'b0;
        n = 0; low = 0; pul = 0; rvc = 0; rvv = '0; done = 1'b0; p = spc6;
        while (!done && n < 300) begin
            @(negedge CLK);
            n++;
            if (!p && spc6) pul++;
            p = spc6;
            if (rvalid6) begin
                rvc++;
                rvv = rdata6;
            end
            if (!ordy6) low++;
            else done = 1'b1;
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_ordy_low_cycles", low, FRAME6_CYC);
        chk("t6_spc_pulses", pul, 32'd24);
        chk("t6_rvalid_count", rvc, 32'd1);
        chk("t6_rdata", 32'(rvv), 32'hBEEF);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", exp_d_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
